unary_frame_gen: RTL and testbench

Converts an accepted population count N into a 255-bit thermometer frame: N ones followed by 255−N zeros. The frame is available in parallel on one output and streamed serially, one bit per handshake, on another. It is the generating end of the popcount path: `popcount(thermo) == N` for every accepted N. It feeds the popcount checker and serial test links.

---
 rtl/unary_frame_gen.sv | 102 ++++++++++
 tb/tb_unary_frame_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/unary_frame_gen.sv
// Thermometer frame generator: latches a count N, publishes an N-ones frame in
// parallel and streams it bit by bit over a valid/ready link.
module unary_frame_gen #(
  parameter int unsigned FRAME_LEN = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_valid,
  output logic                 cnt_ready,
  input  logic [CNT_W-1:0]     cnt,
  output logic [FRAME_LEN-1:0] thermo,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 bit_out,
  output logic                 bit_last,
  output logic [CNT_W-1:0]     ones_sent,
  output logic                 done
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic [7:0]           idx_q, idx_d;
  logic [FRAME_LEN-1:0] thermo_q, thermo_d;
  logic                 done_q, done_d;

  logic in_send, cur_bit, at_last, accept, fire;

  assign in_send = (state_q == SEND);
  assign cur_bit = (32'(idx_q) < 32'(n_q));
  assign at_last = (idx_q == 8'(FRAME_LEN - 1));

  // Serial outputs come only from registered state, never from bit_ready.
  assign cnt_ready = !in_send && !rst;
  assign bit_valid = in_send;
  assign bit_out   = in_send && cur_bit;
  assign bit_last  = in_send && at_last;
  assign thermo    = thermo_q;
  assign ones_sent = ones_q;
  assign done      = done_q;

  assign accept = cnt_valid && cnt_ready;
  assign fire   = in_send && bit_ready;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ones_d   = ones_q;
    idx_d    = idx_q;
    thermo_d = thermo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          n_d = (32'(cnt) > FRAME_LEN) ? CNT_W'(FRAME_LEN) : cnt;
          for (int unsigned i = 0; i < FRAME_LEN; i++) begin
            thermo_d[i] = (i < 32'(n_d));
          end
          idx_d   = '0;
          ones_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (cur_bit) begin
            ones_d = ones_q + CNT_W'(1);
          end
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
      thermo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
      thermo_q <= thermo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_unary_frame_gen.sv
// Randomized bench for unary_frame_gen: each frame is predicted from N alone
// (bit j of the frame is 1 exactly when j < N) and compared cycle by cycle.
module tb_unary_frame_gen;

  localparam int unsigned FRAME_LEN = 255;
  localparam int unsigned CNT_W     = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cnt_valid;
  logic                 cnt_ready;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] thermo;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 bit_out;
  logic                 bit_last;
  logic [CNT_W-1:0]     ones_sent;
  logic                 done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  unary_frame_gen #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt       (cnt),
    .thermo    (thermo),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_last  (bit_last),
    .ones_sent (ones_sent),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME_LEN-1:0] model_frame(input int unsigned n);
    logic [FRAME_LEN-1:0] f;
    for (int unsigned i = 0; i < FRAME_LEN; i++) f[i] = (i < n);
    return f;
  endfunction

  // Starts in an IDLE cycle, returns positioned in the done cycle.
  // hold keeps cnt_valid high during SEND with next_n on cnt.
  task automatic send_frame(input int unsigned n, input int unsigned pct,
                            input bit hold, input int unsigned next_n);
    logic [FRAME_LEN-1:0] exp_f;
    int unsigned j, cyc;
    bit rdy;
    exp_f = model_frame(n);
    chk("cnt_ready_idle", cnt_ready, 1'b1);
    chk("bit_valid_idle", bit_valid, 1'b0);
    cnt       = CNT_W'(n);
    cnt_valid = 1'b1;
    tick();
    cnt_valid = hold;
    cnt       = CNT_W'(next_n);
    chk("thermo", thermo, exp_f);
    chk("popcount", $countones(thermo), n);
    j   = 0;
    cyc = 0;
    while (j < FRAME_LEN && cyc < 5000) begin
      rdy       = ($urandom_range(0, 99) < pct);
      bit_ready = rdy;
      chk("bit_valid", bit_valid, 1'b1);
      chk("bit_out", bit_out, (j < n));
      chk("bit_last", bit_last, (j == FRAME_LEN - 1));
      chk("ones_sent_mid", ones_sent, (j < n) ? j : n);
      chk("cnt_ready_send", cnt_ready, 1'b0);
      chk("done_mid", done, 1'b0);
      tick();
      cyc++;
      if (rdy) j++;
    end
    if (j < FRAME_LEN) chk("frame_timeout", j, FRAME_LEN);
    chk("done_pulse", done, 1'b1);
    chk("cnt_ready_done", cnt_ready, 1'b1);
    chk("bit_valid_done", bit_valid, 1'b0);
    chk("ones_sent_end", ones_sent, n);
    chk("thermo_end", thermo, exp_f);
  endtask

  initial begin
    rst       = 1'b1;
    cnt_valid = 1'b0;
    cnt       = '0;
    bit_ready = 1'b0;
    tick();
    tick();
    chk("rst_cnt_ready", cnt_ready, 1'b0);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_bit_out", bit_out, 1'b0);
    chk("rst_bit_last", bit_last, 1'b0);
    chk("rst_thermo", thermo, '0);
    chk("rst_ones", ones_sent, '0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    #1;

    send_frame(0, 100, 1'b0, 0);
    chk("thermo_zero", thermo, '0);
    tick();
    chk("done_drop0", done, 1'b0);

    send_frame(255, 100, 1'b0, 0);
    tick();
    chk("done_once255", done, 1'b0);
    chk("thermo_hold", thermo, model_frame(255));
    chk("ones_hold", ones_sent, 8'd255);

    send_frame(100, 50, 1'b0, 0);
    tick();

    // Back-to-back: second accept lands in the done cycle of the first.
    send_frame(3, 100, 1'b1, 7);
    send_frame(7, 70, 1'b0, 0);
    tick();
    chk("done_drop7", done, 1'b0);

    cnt       = 8'd200;
    cnt_valid = 1'b1;
    tick();
    cnt_valid = 1'b0;
    bit_ready = 1'b1;
    repeat (50) tick();
    chk("pre_rst_ones", ones_sent, 8'd50);
    chk("pre_rst_thermo", thermo, model_frame(200));
    rst = 1'b1;
    tick();
    chk("abort_bit_valid", bit_valid, 1'b0);
    chk("abort_thermo", thermo, '0);
    chk("abort_ones", ones_sent, '0);
    chk("abort_done", done, 1'b0);
    chk("abort_cnt_ready", cnt_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_done_after", done, 1'b0);
    send_frame(5, 100, 1'b0, 0);
    tick();

    for (int k = 0; k < 3; k++) begin
      send_frame($urandom_range(0, 255), 60, 1'b0, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
